// File: rtl/cycloneiiils_pll_scan_tx.sv
// Serial scan-chain loader for the PLL: shifts cfg_data out MSB-first, pulses configupdate, then done.
// Optional readback of the old chain contents via `define CYCLONEIIILS_PLL_SCAN_READBACK_EN.
module cycloneiiils_pll_scan_tx #(
  parameter int WIDTH       = 144,
  parameter int UPDATE_WAIT = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             scandataout,
  output logic             scandata,
  output logic             scanclkena,
  output logic             configupdate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rb_data
);

  localparam int CMAX = (WIDTH > UPDATE_WAIT) ? WIDTH : UPDATE_WAIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, UPDATE, WAIT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // Outputs are computed from the next state so each is a plain flop.
  // One counter serves both the shift length and the post-update wait.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      scandata     <= 1'b0;
      scanclkena   <= 1'b0;
      configupdate <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      scandata     <= 1'b0;
      scanclkena   <= 1'b0;
      configupdate <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= SHIFT;
            sr         <= cfg_data;
            cnt        <= CW'(WIDTH);
            scandata   <= cfg_data[WIDTH-1];
            scanclkena <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state        <= UPDATE;
              configupdate <= 1'b1;
            end else begin
              scandata   <= sr[WIDTH-2];
              scanclkena <= 1'b1;
            end
          end
        end
        UPDATE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= CW'(UPDATE_WAIT);
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CYCLONEIIILS_PLL_SCAN_READBACK_EN
  // The far end returns the old chain one bit per shift; outside SHIFT the value just holds.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      rb_data <= '0;
    else if (state == SHIFT)
      rb_data <= {rb_data[WIDTH-2:0], scandataout};
  end
`else
  logic unused_scandataout;
  assign unused_scandataout = scandataout;
  assign rb_data            = '0;
`endif

endmodule

// File: tb/tb_cycloneiiils_pll_scan_tx.sv
// Directed bench for cycloneiiils_pll_scan_tx at WIDTH=8, UPDATE_WAIT=4.
module tb_cycloneiiils_pll_scan_tx;

  localparam int W  = 8;
  localparam int UW = 4;

  logic         clk = 1'b0;
  logic         clrn, start, abort, scandataout;
  logic [W-1:0] cfg_data;
  logic         scandata, scanclkena, configupdate, busy, done;
  logic [W-1:0] rb_data;

  int n_chk  = 0;
  int n_fail = 0;

  cycloneiiils_pll_scan_tx #(.WIDTH(W), .UPDATE_WAIT(UW)) dut (
    .clk(clk), .clrn(clrn), .start(start), .abort(abort),
    .cfg_data(cfg_data), .scandataout(scandataout),
    .scandata(scandata), .scanclkena(scanclkena), .configupdate(configupdate),
    .busy(busy), .done(done), .rb_data(rb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sd"},  {31'd0, scandata},     32'd0);
    chk({tag, "_ena"}, {31'd0, scanclkena},   32'd0);
    chk({tag, "_upd"}, {31'd0, configupdate}, 32'd0);
    chk({tag, "_bsy"}, {31'd0, busy},         32'd0);
    chk({tag, "_dn"},  {31'd0, done},         32'd0);
  endtask

  // Full transfer from an IDLE cycle; leaves the bench in the IDLE cycle after DONE.
  task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] nxt,
                      input logic [W-1:0] rb, input logic hold);
    logic [W-1:0] rb_exp;
`ifdef CYCLONEIIILS_PLL_SCAN_READBACK_EN
    rb_exp = rb;
`else
    rb_exp = '0;
`endif
    start = 1'b1; cfg_data = d;
    step();
    start = hold; cfg_data = nxt;
    for (int i = 0; i < W; i++) begin
      chk("shift_sd",  {31'd0, scandata},   {31'd0, d[W-1-i]});
      chk("shift_ena", {31'd0, scanclkena}, 32'd1);
      chk("shift_bsy", {31'd0, busy},       32'd1);
      scandataout = rb[W-1-i];
      step();
    end
    scandataout = 1'b0;
    chk("upd_pulse", {31'd0, configupdate}, 32'd1);
    chk("upd_ena",   {31'd0, scanclkena},   32'd0);
    chk("upd_sd",    {31'd0, scandata},     32'd0);
    step();
    for (int j = 0; j < UW; j++) begin
      chk("wait_upd", {31'd0, configupdate}, 32'd0);
      chk("wait_ena", {31'd0, scanclkena},   32'd0);
      chk("wait_dn",  {31'd0, done},         32'd0);
      chk("wait_bsy", {31'd0, busy},         32'd1);
      if (j == 1) start = 1'b1;
      if (j == 2) start = hold;
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_bsy",   {31'd0, busy}, 32'd1);
    chk("done_rb",    {24'd0, rb_data}, {24'd0, rb_exp});
    step();
    chk("post_dn",  {31'd0, done}, 32'd0);
    chk("post_bsy", {31'd0, busy}, 32'd0);
    chk("post_ena", {31'd0, scanclkena}, 32'd0);
  endtask

  initial begin
    logic seen;
    clrn = 1'b0; start = 1'b0; abort = 1'b0; scandataout = 1'b0; cfg_data = '0;
    #22;
    chk_idle("rst");
    chk("rst_rb", {24'd0, rb_data}, 32'd0);
    clrn = 1'b1;
    step();

    // Basic A5 transfer with readback pattern 5A
    xfer(8'hA5, 8'hFF, 8'h5A, 1'b0);
    step();

    // Abort on the 3rd SHIFT cycle
    start = 1'b1; cfg_data = 8'hA5;
    step();
    start = 1'b0;
    step(); step();
    chk("ab_pre_ena", {31'd0, scanclkena}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("ab");
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      seen |= configupdate | done | busy;
    end
    chk("ab_quiet", {31'd0, seen}, 32'd0);

    // Abort in IDLE blocks start
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("ab_idle_bsy", {31'd0, busy},       32'd0);
    chk("ab_idle_ena", {31'd0, scanclkena}, 32'd0);
    step();

    // Abort coinciding with UPDATE: pulse still seen, done suppressed
    start = 1'b1; cfg_data = 8'h0F;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) step();
    chk("abu_upd", {31'd0, configupdate}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abu");
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      seen |= done | configupdate;
    end
    chk("abu_nodone", {31'd0, seen}, 32'd0);

    // Start held high: back-to-back 3C then C3
    xfer(8'h3C, 8'hC3, 8'hF0, 1'b1);
    xfer(8'hC3, 8'h00, 8'h81, 1'b0);
    step();

    // Reset pulsed during WAIT
    start = 1'b1; cfg_data = 8'h96;
    step();
    start = 1'b0;
    for (int i = 0; i < W + 2; i++) step();
    chk("rw_bsy", {31'd0, busy}, 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk_idle("rw");
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen |= done | busy;
    end
    chk("rw_held", {31'd0, seen}, 32'd0);
    clrn = 1'b1;
    xfer(8'h69, 8'h00, 8'h33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
